// File: rtl/serial_mul_rr_scheduler.sv
// -----------------------------------------------------------------------------
// serial_mul_rr_scheduler
//
// Shares a single serial multiplier between N_REQ requesters using round-robin
// arbitration. The winner's operands are latched, START is pulsed for one cycle,
// and the scheduler waits for the multiplier's valid_out. The product is then
// returned on result_o, together with a one-cycle done_o pulse on the winner's lane.
//
// Transaction sequence: IDLE -> LAUNCH -> WAIT -> DONE -> IDLE
//
// Optional feature macro: SERIAL_MUL_TIMEOUT_EN
//   When this macro is defined, a watchdog counts the cycles spent in WAIT.
//   After TIMEOUT_CYCLES cycles with no valid_out, the transaction is closed
//   with result_o = 0 and err_o = 1. Both signals coincide with done_o.
//   When it is undefined, WAIT can last indefinitely and err_o is tied to 0.
//
// Ports
//   PCLK       clock, rising edge
//   PRESETn    asynchronous active-low reset
//   req_i      per-requester request, held until that requester sees done_o
//   op_a_i     packed operand A, requester k at [k*OP_A_WIDTH +: OP_A_WIDTH]
//   op_b_i     packed operand B, same packing
//   gnt_o      one-hot grant, high from LAUNCH through DONE
//   done_o     one-cycle completion pulse on the granted requester's bit
//   result_o   last product, held until the next DONE
//   busy_o     high whenever the FSM is not IDLE
//   err_o      watchdog timeout pulse (0 without SERIAL_MUL_TIMEOUT_EN)
//   IN_A/IN_B  latched operands driven to the multiplier
//   START      one-cycle start pulse to the multiplier
//   OUT        multiplier product
//   valid_out  multiplier result valid
// -----------------------------------------------------------------------------
module serial_mul_rr_scheduler #(
    parameter  int N_REQ          = 4,
    parameter  int OP_A_WIDTH     = 16,
    parameter  int OP_B_WIDTH     = 16,
    parameter  int TIMEOUT_CYCLES = 64,
    localparam int OUT_WIDTH      = OP_A_WIDTH + OP_B_WIDTH
) (
    input  logic                          PCLK,
    input  logic                          PRESETn,
    input  logic [N_REQ-1:0]              req_i,
    input  logic [N_REQ*OP_A_WIDTH-1:0]   op_a_i,
    input  logic [N_REQ*OP_B_WIDTH-1:0]   op_b_i,
    output logic [N_REQ-1:0]              gnt_o,
    output logic [N_REQ-1:0]              done_o,
    output logic [OUT_WIDTH-1:0]          result_o,
    output logic                          busy_o,
    output logic                          err_o,
    output logic [OP_A_WIDTH-1:0]         IN_A,
    output logic [OP_B_WIDTH-1:0]         IN_B,
    output logic                          START,
    input  logic [OUT_WIDTH-1:0]          OUT,
    input  logic                          valid_out
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                 state_q;
    logic [IDX_W-1:0]       ptr_q;
    logic [N_REQ-1:0]       gnt_q;
    logic [N_REQ-1:0]       done_q;
    logic [OUT_WIDTH-1:0]   result_q;
    logic [OP_A_WIDTH-1:0]  a_q;
    logic [OP_B_WIDTH-1:0]  b_q;
    logic                   start_q;
    logic                   busy_q;
    // Low during the first WAIT cycle. valid_out may still show the previous
    // result there if the multiplier has not yet reacted to START.
    logic                   armed_q;

    // Operands unpacked per requester
    logic [OP_A_WIDTH-1:0]  op_a_arr [N_REQ];
    logic [OP_B_WIDTH-1:0]  op_b_arr [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign op_a_arr[gi] = op_a_i[gi*OP_A_WIDTH +: OP_A_WIDTH];
            assign op_b_arr[gi] = op_b_i[gi*OP_B_WIDTH +: OP_B_WIDTH];
        end
    endgenerate

    // Round-robin pick: the first set request found searching upward from ptr+1.
    // The loop scans from the farthest candidate to the nearest one.
    // The nearest set bit is therefore the last assignment, and it wins.
    logic                   win_valid_d;
    logic [IDX_W-1:0]       win_idx_d;
    logic [N_REQ-1:0]       win_onehot_d;

    always_comb begin
        logic [IDX_W-1:0] cand;
        win_valid_d  = 1'b0;
        win_idx_d    = '0;
        win_onehot_d = '0;
        cand         = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            cand = IDX_W'((int'(ptr_q) + i) % N_REQ);
            if (req_i[cand]) begin
                win_valid_d = 1'b1;
                win_idx_d   = cand;
            end
        end
        win_onehot_d[win_idx_d] = 1'b1;
    end

`ifdef SERIAL_MUL_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt_q;
    logic             err_q;
    assign err_o = err_q;
`else
    // The watchdog is not built in this configuration.
    // The empty block below only keeps TIMEOUT_CYCLES referenced, with its legal range noted.
    generate
        if (TIMEOUT_CYCLES < 1) begin : g_timeout_out_of_range
        end
    endgenerate
    assign err_o = 1'b0;
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q    <= S_IDLE;
            ptr_q      <= IDX_W'(N_REQ - 1);
            gnt_q      <= '0;
            done_q     <= '0;
            result_q   <= '0;
            a_q        <= '0;
            b_q        <= '0;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            armed_q    <= 1'b0;
`ifdef SERIAL_MUL_TIMEOUT_EN
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (win_valid_d) begin
                        a_q     <= op_a_arr[win_idx_d];
                        b_q     <= op_b_arr[win_idx_d];
                        gnt_q   <= win_onehot_d;
                        ptr_q   <= win_idx_d;
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    start_q    <= 1'b0;
                    armed_q    <= 1'b0;
`ifdef SERIAL_MUL_TIMEOUT_EN
                    wait_cnt_q <= '0;
`endif
                    state_q    <= S_WAIT;
                end
                S_WAIT: begin
                    armed_q    <= 1'b1;
`ifdef SERIAL_MUL_TIMEOUT_EN
                    wait_cnt_q <= wait_cnt_q + 1'b1;
`endif
                    if (armed_q && valid_out) begin
                        result_q <= OUT;
                        done_q   <= gnt_q;
                        state_q  <= S_DONE;
                    end
`ifdef SERIAL_MUL_TIMEOUT_EN
                    // The last permitted WAIT cycle has ended without a result.
                    else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        result_q <= '0;
                        done_q   <= gnt_q;
                        err_q    <= 1'b1;
                        state_q  <= S_DONE;
                    end
`endif
                end
                S_DONE: begin
                    done_q  <= '0;
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
`ifdef SERIAL_MUL_TIMEOUT_EN
                    err_q   <= 1'b0;
`endif
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign gnt_o    = gnt_q;
    assign done_o   = done_q;
    assign result_o = result_q;
    assign busy_o   = busy_q;
    assign IN_A     = a_q;
    assign IN_B     = b_q;
    assign START    = start_q;

endmodule

// File: tb/tb_serial_mul_rr_scheduler.sv
// Directed testbench for serial_mul_rr_scheduler (N_REQ=4, 16x16 operands).
// The bench plays the role of the multiplier: it drives OUT/valid_out with
// hand-computed products. All DUT outputs are sampled on the falling edge.
module tb_serial_mul_rr_scheduler;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic [3:0]  req_i = '0;
    logic [63:0] op_a_i = '0;
    logic [63:0] op_b_i = '0;
    logic [3:0]  gnt_o;
    logic [3:0]  done_o;
    logic [31:0] result_o;
    logic        busy_o;
    logic        err_o;
    logic [15:0] IN_A;
    logic [15:0] IN_B;
    logic        START;
    logic [31:0] OUT = '0;
    logic        valid_out = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    serial_mul_rr_scheduler dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .req_i     (req_i),
        .op_a_i    (op_a_i),
        .op_b_i    (op_b_i),
        .gnt_o     (gnt_o),
        .done_o    (done_o),
        .result_o  (result_o),
        .busy_o    (busy_o),
        .err_o     (err_o),
        .IN_A      (IN_A),
        .IN_B      (IN_B),
        .START     (START),
        .OUT       (OUT),
        .valid_out (valid_out)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge PCLK);
    endtask

    // Runs a single transaction, acting as the multiplier. It starts from an IDLE
    // falling edge with req_i already driven, and returns at the IDLE falling edge
    // that follows DONE. wait_ticks is -1 when START was never seen.
    task automatic do_txn(input int lat, input logic [31:0] product,
                          output int wait_ticks, output logic [3:0] gnt_seen,
                          output logic [15:0] a_seen, output logic [15:0] b_seen,
                          output logic [3:0] done_seen, output logic [31:0] res_seen);
        wait_ticks = 0; gnt_seen = '0; a_seen = '0; b_seen = '0;
        done_seen = '0; res_seen = '0;
        do begin
            tick();
            wait_ticks++;
        end while (START !== 1'b1 && wait_ticks < 20);
        if (START !== 1'b1) begin
            wait_ticks = -1;
            return;
        end
        gnt_seen = gnt_o; a_seen = IN_A; b_seen = IN_B;
        valid_out = 1'b0;
        repeat (lat) tick();
        OUT = product; valid_out = 1'b1;
        tick();
        done_seen = done_o; res_seen = result_o;
        tick();
    endtask

    task automatic test_reset();
        PRESETn = 1'b0;
        tick(); tick();
        n_checks++; if (gnt_o !== 4'b0) $display("FAIL reset_gnt: got %b expected 0000", gnt_o); else n_pass++;
        n_checks++; if (done_o !== 4'b0) $display("FAIL reset_done: got %b expected 0000", done_o); else n_pass++;
        n_checks++; if (result_o !== 32'h0) $display("FAIL reset_result: got %h expected 0", result_o); else n_pass++;
        n_checks++; if ({busy_o, err_o, START} !== 3'b000) $display("FAIL reset_flags: got busy/err/start=%b expected 000", {busy_o, err_o, START}); else n_pass++;
        n_checks++; if ({IN_A, IN_B} !== 32'h0) $display("FAIL reset_operands: got %h expected 0", {IN_A, IN_B}); else n_pass++;
        PRESETn = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int wt; logic [3:0] g, d; logic [15:0] a, b; logic [31:0] r;
        req_i = 4'b0010;
        op_a_i[16 +: 16] = 16'd3;
        op_b_i[16 +: 16] = 16'd5;
        do_txn(17, 32'd15, wt, g, a, b, d, r);
        req_i = 4'b0000;
        $display("basic: gnt=%b a=%0d b=%0d done=%b result=%0d", g, a, b, d, r);
        n_checks++; if (wt !== 1) $display("FAIL basic_start_latency: got %0d expected 1", wt); else n_pass++;
        n_checks++; if (g !== 4'b0010) $display("FAIL basic_gnt: got %b expected 0010", g); else n_pass++;
        n_checks++; if ({a, b} !== {16'd3, 16'd5}) $display("FAIL basic_operands: got %h expected 00030005", {a, b}); else n_pass++;
        n_checks++; if (d !== 4'b0010) $display("FAIL basic_done: got %b expected 0010", d); else n_pass++;
        n_checks++; if (r !== 32'd15) $display("FAIL basic_result: got %0d expected 15", r); else n_pass++;
        n_checks++; if ({done_o, gnt_o, busy_o} !== 9'b0) $display("FAIL basic_after: got done/gnt/busy=%b expected 0", {done_o, gnt_o, busy_o}); else n_pass++;
        n_checks++; if (result_o !== 32'd15) $display("FAIL basic_result_hold: got %0d expected 15", result_o); else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [15:0] ta [4];
        logic [15:0] tbv [4];
        logic [31:0] tp [4];
        int wt; logic [3:0] g, d, exp_g; logic [15:0] a, b; logic [31:0] r;
        ta  = '{16'hFFFF, 16'h1234, 16'h0007, 16'h8000};
        tbv = '{16'hFFFF, 16'h0010, 16'h0009, 16'h0002};
        tp  = '{32'hFFFE0001, 32'h00012340, 32'd63, 32'h00010000};
        // restart from reset so the pointer begins at N_REQ-1
        PRESETn = 1'b0; valid_out = 1'b0; tick(); PRESETn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            op_a_i[k*16 +: 16] = ta[k];
            op_b_i[k*16 +: 16] = tbv[k];
        end
        req_i = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            int k;
            k = i % 4;
            exp_g = 4'b0001 << k;
            if (i == 7) begin
                // drop requests once the last grant is out (req is sampled only in IDLE)
                do_txn(2 + i, tp[k], wt, g, a, b, d, r);
                req_i = 4'b0000;
            end else begin
                do_txn(2 + i, tp[k], wt, g, a, b, d, r);
            end
            $display("rr txn %0d: gnt=%b a=%h b=%h done=%b result=%h", i, g, a, b, d, r);
            n_checks++; if (wt !== 1) $display("FAIL rr_gap_%0d: got %0d idle cycles expected 1", i, wt); else n_pass++;
            n_checks++; if (g !== exp_g) $display("FAIL rr_gnt_%0d: got %b expected %b", i, g, exp_g); else n_pass++;
            n_checks++; if ({a, b} !== {ta[k], tbv[k]}) $display("FAIL rr_operands_%0d: got %h expected %h", i, {a, b}, {ta[k], tbv[k]}); else n_pass++;
            n_checks++; if (d !== exp_g) $display("FAIL rr_done_%0d: got %b expected %b", i, d, exp_g); else n_pass++;
            n_checks++; if (r !== tp[k]) $display("FAIL rr_result_%0d: got %h expected %h", i, r, tp[k]); else n_pass++;
            n_checks++; if ({done_o, busy_o} !== 5'b0) $display("FAIL rr_idle_%0d: got done/busy=%b expected 0", i, {done_o, busy_o}); else n_pass++;
        end
    endtask

    task automatic test_wrap();
        int wt; logic [3:0] g, d; logic [15:0] a, b; logic [31:0] r;
        // the pointer is now 3
        op_a_i[0 +: 16]  = 16'd2;  op_b_i[0 +: 16]  = 16'd3;
        op_a_i[48 +: 16] = 16'd10; op_b_i[48 +: 16] = 16'd10;
        req_i = 4'b1001;
        do_txn(4, 32'd6, wt, g, a, b, d, r);
        $display("wrap txn 0: gnt=%b done=%b result=%0d", g, d, r);
        n_checks++; if (g !== 4'b0001) $display("FAIL wrap_first_gnt: got %b expected 0001", g); else n_pass++;
        n_checks++; if (r !== 32'd6) $display("FAIL wrap_first_result: got %0d expected 6", r); else n_pass++;
        do_txn(5, 32'd100, wt, g, a, b, d, r);
        req_i = 4'b0000;
        $display("wrap txn 1: gnt=%b done=%b result=%0d", g, d, r);
        n_checks++; if (g !== 4'b1000) $display("FAIL wrap_second_gnt: got %b expected 1000", g); else n_pass++;
        n_checks++; if ({wt, r} !== {32'd1, 32'd100}) $display("FAIL wrap_second: got gap=%0d result=%0d expected 1/100", wt, r); else n_pass++;
        repeat (3) tick();
        n_checks++; if ({busy_o, START, gnt_o} !== 6'b0) $display("FAIL idle_no_req: got busy/start/gnt=%b expected 0", {busy_o, START, gnt_o}); else n_pass++;
        n_checks++; if (result_o !== 32'd100) $display("FAIL idle_result_hold: got %0d expected 100", result_o); else n_pass++;
    endtask

    task automatic test_change_in_wait();
        valid_out = 1'b0;
        op_a_i[32 +: 16] = 16'h00AA; op_b_i[32 +: 16] = 16'h0055;
        req_i = 4'b0100;
        tick();
        n_checks++; if ({START, gnt_o} !== 5'b1_0100) $display("FAIL chg_launch: got start/gnt=%b expected 10100", {START, gnt_o}); else n_pass++;
        tick();
        op_a_i[32 +: 16] = 16'hFFFF; op_b_i[32 +: 16] = 16'hFFFF;
        req_i = 4'b0000;
        tick();
        n_checks++; if ({IN_A, IN_B} !== {16'h00AA, 16'h0055}) $display("FAIL chg_operands_stable: got %h expected 00aa0055", {IN_A, IN_B}); else n_pass++;
        OUT = 32'h3872; valid_out = 1'b1;
        tick();
        $display("change txn: done=%b result=%h", done_o, result_o);
        n_checks++; if (done_o !== 4'b0100) $display("FAIL chg_done: got %b expected 0100", done_o); else n_pass++;
        n_checks++; if (result_o !== 32'h3872) $display("FAIL chg_result: got %h expected 3872", result_o); else n_pass++;
        tick();
        n_checks++; if ({done_o, busy_o} !== 5'b0) $display("FAIL chg_idle: got done/busy=%b expected 0", {done_o, busy_o}); else n_pass++;
    endtask

    task automatic test_stale_valid();
        // valid_out is still high from the previous product
        op_a_i[0 +: 16] = 16'd4; op_b_i[0 +: 16] = 16'd4;
        req_i = 4'b0001;
        tick();
        n_checks++; if ({START, gnt_o} !== 5'b1_0001) $display("FAIL stale_launch: got start/gnt=%b expected 10001", {START, gnt_o}); else n_pass++;
        tick();
        tick();
        n_checks++; if ({done_o, busy_o} !== 5'b0000_1) $display("FAIL stale_accepted: got done/busy=%b expected 00001", {done_o, busy_o}); else n_pass++;
        valid_out = 1'b0; req_i = 4'b0000;
        tick();
        OUT = 32'd16; valid_out = 1'b1;
        tick();
        $display("stale txn: done=%b result=%0d", done_o, result_o);
        n_checks++; if (done_o !== 4'b0001) $display("FAIL stale_done: got %b expected 0001", done_o); else n_pass++;
        n_checks++; if (result_o !== 32'd16) $display("FAIL stale_result: got %0d expected 16", result_o); else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid();
        valid_out = 1'b0;
        op_a_i[16 +: 16] = 16'd5; op_b_i[16 +: 16] = 16'd6;
        req_i = 4'b0010;
        tick(); tick(); tick();
        n_checks++; if ({busy_o, gnt_o} !== 5'b1_0010) $display("FAIL rstmid_in_wait: got busy/gnt=%b expected 10010", {busy_o, gnt_o}); else n_pass++;
        #2 PRESETn = 1'b0;
        #1;
        n_checks++; if ({gnt_o, done_o, busy_o, START} !== 10'b0) $display("FAIL rstmid_async_ctrl: got %b expected 0", {gnt_o, done_o, busy_o, START}); else n_pass++;
        n_checks++; if ({IN_A, IN_B, result_o} !== 64'h0) $display("FAIL rstmid_async_data: got %h expected 0", {IN_A, IN_B, result_o}); else n_pass++;
        OUT = 32'd30; valid_out = 1'b1;
        tick(); tick();
        req_i = 4'b0000;
        PRESETn = 1'b1;
        tick(); tick();
        $display("reset-mid: done=%b busy=%b result=%0d", done_o, busy_o, result_o);
        n_checks++; if ({done_o, busy_o} !== 5'b0) $display("FAIL rstmid_after: got done/busy=%b expected 0", {done_o, busy_o}); else n_pass++;
        n_checks++; if (result_o !== 32'h0) $display("FAIL rstmid_result: got %0d expected 0", result_o); else n_pass++;
    endtask

`ifdef SERIAL_MUL_TIMEOUT_EN
    task automatic test_timeout();
        int k;
        valid_out = 1'b0;
        op_a_i[0 +: 16] = 16'd1; op_b_i[0 +: 16] = 16'd1;
        req_i = 4'b0001;
        tick();
        k = 0;
        while (done_o !== 4'b0001 && k < 200) begin
            tick();
            k++;
        end
        $display("timeout txn: cycles=%0d done=%b err=%b result=%0d", k, done_o, err_o, result_o);
        n_checks++; if (k !== 65) $display("FAIL timeout_cycles: got %0d expected 65", k); else n_pass++;
        n_checks++; if ({err_o, result_o} !== 33'h1_0000_0000) $display("FAIL timeout_err_result: got err=%b result=%h expected 1/0", err_o, result_o); else n_pass++;
        req_i = 4'b0000;
        tick();
        n_checks++; if ({err_o, busy_o} !== 2'b00) $display("FAIL timeout_after: got err/busy=%b expected 00", {err_o, busy_o}); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_wrap();
        test_change_in_wait();
        test_stale_valid();
        test_reset_mid();
`ifdef SERIAL_MUL_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
